conv_tap_sequencer: RTL and testbench

- Generates the kernel-tap address stream for one convolution pass over a feature map stored row-major in on-chip RAM.
- Walks output positions (row, col) and, within each position, kernel taps (kr, kc).
- Emits one tap address per valid/ready handshake, with window-first and window-last markers.
- Sits directly upstream of the MAC/accumulator stage. Its tap_last flag drives that stage's per-window tap counter enable and clear.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_tap_sequencer_idx_cnt.sv | 42 ++++
 rtl/conv_tap_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_conv_tap_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution tap sequencer.
//   state_e : sequencer FSM states
//   tap_t   : tap payload bundle, sized for the largest supported configuration
//   out_dim : number of output positions along one axis for a given image/kernel/stride
package conv_pkg;

  // Upper bounds for the payload bundle; instances slice down to their own widths.
  localparam int unsigned TapAddrW = 24;
  localparam int unsigned TapIdxW  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic [TapAddrW-1:0] addr;
    logic [TapIdxW-1:0]  kr;
    logic [TapIdxW-1:0]  kc;
    logic                first;
    logic                last;
    logic                frame_last;
  } tap_t;

  // stride must be >= 1; integer division floors partial windows away.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                          input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_tap_sequencer_idx_cnt.sv
// Wrapping index counter used for kc, kr, out_col and out_row.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear, wins over en_i
//   en_i   : advance by one, wrapping Max -> 0
//   cnt_o  : current index
//   max_o  : index equals Max, i.e. the next advance wraps and carries outward
module conv_tap_sequencer_idx_cnt #(
  parameter int unsigned Width = 4,
  parameter int unsigned Max   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             max_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign max_o = (cnt_q == Width'(Max));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = max_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_tap_sequencer.sv
// Kernel-tap address generator for one convolution pass over a row-major feature map.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i             : begin a pass (only honoured when idle)
//   abort_i             : cancel a running pass, no done pulse
//   busy_o, done_o      : running / one-cycle end-of-pass pulse
//   tap_valid_o/ready_i : tap handshake
//   tap_addr_o          : (out_row*STRIDE+kr)*IMG_W + out_col*STRIDE + kc
//   tap_kr_o, tap_kc_o  : kernel row/column of the current tap
//   tap_first_o/last_o  : first/last tap of a window; frame_last_o marks the last tap of the pass
//   out_row_o/out_col_o : current output position
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 5,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H),
  localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE),
  localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE),
  localparam int unsigned KW    = $clog2(K + 1),
  localparam int unsigned RowW  = $clog2(OUT_H + 1),
  localparam int unsigned ColW  = $clog2(OUT_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              tap_valid_o,
  input  logic              tap_ready_i,
  output logic [ADDR_W-1:0] tap_addr_o,
  output logic [KW-1:0]     tap_kr_o,
  output logic [KW-1:0]     tap_kc_o,
  output logic              tap_first_o,
  output logic              tap_last_o,
  output logic              frame_last_o,
  output logic [RowW-1:0]   out_row_o,
  output logic [ColW-1:0]   out_col_o
);

  localparam logic [ADDR_W-1:0] KrStep  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ColStep = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(STRIDE * IMG_W);

  state_e state_q;
  logic   busy_q, done_q;

  logic            hs, clr, frame_end;
  logic            en_kr, en_col, en_row;
  logic            kc_max, kr_max, col_max, row_max;
  logic [KW-1:0]   kc_cnt, kr_cnt;
  logic [ColW-1:0] col_cnt;
  logic [RowW-1:0] row_cnt;

  logic [ADDR_W-1:0] kr_off_q, kr_off_d;
  logic [ADDR_W-1:0] col_base_q, col_base_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  tap_t tap;

  // busy_q is high exactly while in StRun, so it doubles as tap_valid.
  assign hs        = busy_q & tap_ready_i;
  // Indices are held at zero outside a pass; abort wins over a same-cycle handshake.
  assign clr       = ~busy_q | abort_i;
  assign frame_end = kc_max & kr_max & col_max & row_max;

  // Carry chain, innermost first.
  assign en_kr  = hs & kc_max;
  assign en_col = en_kr & kr_max;
  assign en_row = en_col & col_max;

  conv_tap_sequencer_idx_cnt #(.Width(KW), .Max(K - 1)) u_cnt_kc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .en_i  (hs),
    .cnt_o (kc_cnt),
    .max_o (kc_max)
  );

  conv_tap_sequencer_idx_cnt #(.Width(KW), .Max(K - 1)) u_cnt_kr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .en_i  (en_kr),
    .cnt_o (kr_cnt),
    .max_o (kr_max)
  );

  conv_tap_sequencer_idx_cnt #(.Width(ColW), .Max(OUT_W - 1)) u_cnt_col (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .en_i  (en_col),
    .cnt_o (col_cnt),
    .max_o (col_max)
  );

  conv_tap_sequencer_idx_cnt #(.Width(RowW), .Max(OUT_H - 1)) u_cnt_row (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .en_i  (en_row),
    .cnt_o (row_cnt),
    .max_o (row_max)
  );

  // Address bases track the counters: kr*IMG_W, out_col*STRIDE, out_row*STRIDE*IMG_W.
  always_comb begin
    kr_off_d   = kr_off_q;
    col_base_d = col_base_q;
    row_base_d = row_base_q;
    if (clr) begin
      kr_off_d   = '0;
      col_base_d = '0;
      row_base_d = '0;
    end else begin
      if (en_kr)  kr_off_d   = kr_max  ? '0 : kr_off_q + KrStep;
      if (en_col) col_base_d = col_max ? '0 : col_base_q + ColStep;
      if (en_row) row_base_d = row_max ? '0 : row_base_q + RowStep;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kr_off_q   <= '0;
      col_base_q <= '0;
      row_base_q <= '0;
    end else begin
      kr_off_q   <= kr_off_d;
      col_base_q <= col_base_d;
      row_base_q <= row_base_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (abort_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (hs && frame_end) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Flags are gated with busy_q so every output reads zero outside a pass.
  always_comb begin
    tap            = '0;
    tap.addr       = TapAddrW'(row_base_q + col_base_q + kr_off_q + ADDR_W'(kc_cnt));
    tap.kr         = TapIdxW'(kr_cnt);
    tap.kc         = TapIdxW'(kc_cnt);
    tap.first      = busy_q & (kr_cnt == '0) & (kc_cnt == '0);
    tap.last       = busy_q & kr_max & kc_max;
    tap.frame_last = busy_q & frame_end;
  end

  logic unused_tap;
  assign unused_tap = ^tap;

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign tap_valid_o  = busy_q;
  assign tap_addr_o   = tap.addr[ADDR_W-1:0];
  assign tap_kr_o     = tap.kr[KW-1:0];
  assign tap_kc_o     = tap.kc[KW-1:0];
  assign tap_first_o  = tap.first;
  assign tap_last_o   = tap.last;
  assign frame_last_o = tap.frame_last;
  assign out_row_o    = row_cnt;
  assign out_col_o    = col_cnt;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
module tb_conv_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, ready, sel;

  // Instance A: 4x4 image, K=3, stride 1
  logic       a_busy, a_done, a_valid, a_first, a_last, a_fl;
  logic [3:0] a_addr;
  logic [1:0] a_kr, a_kc, a_row, a_col;
  // Instance B: 5x5 image, K=3, stride 2
  logic       b_busy, b_done, b_valid, b_first, b_last, b_fl;
  logic [4:0] b_addr;
  logic [1:0] b_kr, b_kc, b_row, b_col;

  conv_tap_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start & ~sel),
    .abort_i      (abort & ~sel),
    .busy_o       (a_busy),
    .done_o       (a_done),
    .tap_valid_o  (a_valid),
    .tap_ready_i  (ready),
    .tap_addr_o   (a_addr),
    .tap_kr_o     (a_kr),
    .tap_kc_o     (a_kc),
    .tap_first_o  (a_first),
    .tap_last_o   (a_last),
    .frame_last_o (a_fl),
    .out_row_o    (a_row),
    .out_col_o    (a_col)
  );

  conv_tap_sequencer #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2)) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start & sel),
    .abort_i      (abort & sel),
    .busy_o       (b_busy),
    .done_o       (b_done),
    .tap_valid_o  (b_valid),
    .tap_ready_i  (ready),
    .tap_addr_o   (b_addr),
    .tap_kr_o     (b_kr),
    .tap_kc_o     (b_kc),
    .tap_first_o  (b_first),
    .tap_last_o   (b_last),
    .frame_last_o (b_fl),
    .out_row_o    (b_row),
    .out_col_o    (b_col)
  );

  // View of whichever instance is selected.
  logic [31:0] v_busy, v_done, v_valid, v_first, v_last, v_fl, v_addr, v_kr, v_kc, v_row, v_col;
  always_comb begin
    if (sel) begin
      v_busy = 32'(b_busy);  v_done = 32'(b_done);  v_valid = 32'(b_valid);
      v_first = 32'(b_first); v_last = 32'(b_last); v_fl = 32'(b_fl);
      v_addr = 32'(b_addr);  v_kr = 32'(b_kr); v_kc = 32'(b_kc);
      v_row = 32'(b_row);    v_col = 32'(b_col);
    end else begin
      v_busy = 32'(a_busy);  v_done = 32'(a_done);  v_valid = 32'(a_valid);
      v_first = 32'(a_first); v_last = 32'(a_last); v_fl = 32'(a_fl);
      v_addr = 32'(a_addr);  v_kr = 32'(a_kr); v_kc = 32'(a_kc);
      v_row = 32'(a_row);    v_col = 32'(a_col);
    end
  end

  int cfg_w, cfg_k, cfg_s, cfg_ow, cfg_oh;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int total_taps();
    return cfg_oh * cfg_ow * cfg_k * cfg_k;
  endfunction

  // Reference: tap t of the pass, decoded straight from the nesting order.
  task automatic model(input int t, output int addr, output int kr, output int kc,
                       output int row, output int col, output int first, output int last,
                       output int fl);
    int kk, win, tp;
    kk    = cfg_k * cfg_k;
    win   = t / kk;
    tp    = t % kk;
    row   = win / cfg_ow;
    col   = win % cfg_ow;
    kr    = tp / cfg_k;
    kc    = tp % cfg_k;
    addr  = (row * cfg_s + kr) * cfg_w + col * cfg_s + kc;
    first = (tp == 0) ? 1 : 0;
    last  = (tp == kk - 1) ? 1 : 0;
    fl    = (t == total_taps() - 1) ? 1 : 0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, v_valid, 0);
    check({tag, "_busy"}, v_busy, 0);
    check({tag, "_done"}, v_done, 0);
    check({tag, "_addr"}, v_addr, 0);
    check({tag, "_kr"}, v_kr, 0);
    check({tag, "_kc"}, v_kc, 0);
    check({tag, "_first"}, v_first, 0);
    check({tag, "_last"}, v_last, 0);
    check({tag, "_fl"}, v_fl, 0);
    check({tag, "_row"}, v_row, 0);
    check({tag, "_col"}, v_col, 0);
  endtask

  // One pass on the selected instance. start_at/abort_at are 0-based tap indices, -1 = unused.
  task automatic run_pass(input bit rnd, input int start_at, input int abort_at);
    int  hs, cyc, dn, total;
    bit  ended, was_hs, was_last, aborted;
    int  e_addr, e_kr, e_kc, e_row, e_col, e_first, e_last, e_fl;
    hs = 0; cyc = 0; dn = 0; ended = 0; aborted = 0;
    total = total_taps();
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    check("first_tap_latency", v_valid, 1);
    while (!ended) begin
      if (cyc >= 2000) begin
        check("pass_timeout_hs", hs, total);
        ended = 1;
      end else begin
        if (v_done != 0) dn++;
        if (v_valid != 0) begin
          model(hs, e_addr, e_kr, e_kc, e_row, e_col, e_first, e_last, e_fl);
          check("tap_addr", v_addr, e_addr);
          check("tap_kr", v_kr, e_kr);
          check("tap_kc", v_kc, e_kc);
          check("out_row", v_row, e_row);
          check("out_col", v_col, e_col);
          check("tap_first", v_first, e_first);
          check("tap_last", v_last, e_last);
          check("frame_last", v_fl, e_fl);
          check("busy_in_run", v_busy, 1);
          if (!sel) begin
            if (hs == 0)  check("specA_tap1_addr", v_addr, 0);
            if (hs == 8)  check("specA_tap9_addr", v_addr, 10);
            if (hs == 9)  check("specA_tap10_first", v_first, 1);
            if (hs == 18) check("specA_tap19_addr", v_addr, 4);
            if (hs == 35) check("specA_tap36_addr", v_addr, 15);
          end else begin
            if (hs == 27) check("specB_win11_addr", v_addr, 12);
            if (hs == 35) check("specB_final_addr", v_addr, 24);
          end
        end
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hs == start_at) start = 1'b1;
        if (abort_at >= 0 && hs == abort_at && v_valid != 0) begin
          abort = 1'b1;
          ready = 1'b1;
        end
        was_hs   = (v_valid != 0) && ready;
        was_last = (v_fl != 0);
        step();
        start = 1'b0;
        cyc++;
        if (abort) begin
          abort = 1'b0;
          aborted = 1;
          check("abort_valid", v_valid, 0);
          check("abort_busy", v_busy, 0);
          check("abort_done", v_done, 0);
          check("abort_row", v_row, 0);
          check("abort_kc", v_kc, 0);
          step();
          check("abort_done_later", v_done, 0);
          check("abort_stays_idle", v_valid, 0);
          ended = 1;
        end else if (was_hs) begin
          hs++;
          if (was_last) begin
            dn += (v_done != 0) ? 1 : 0;
            check("done_pulse", v_done, 1);
            check("done_valid", v_valid, 0);
            check("done_busy", v_busy, 0);
            check("hs_count", hs, total);
            if (start_at >= 0) start = 1'b1;
            step();
            start = 1'b0;
            check("done_one_cycle", v_done, 0);
            check("no_restart_valid", v_valid, 0);
            step();
            check("no_restart_busy", v_busy, 0);
            ended = 1;
          end
        end
      end
    end
    check("done_pulse_count", dn, aborted ? 0 : 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0;
    cfg_w = 4; cfg_k = 3; cfg_s = 1; cfg_ow = 2; cfg_oh = 2;
    step();
    step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();

    run_pass(1'b0, -1, -1);   // ready tied high
    step();
    run_pass(1'b1, -1, -1);   // random stalls
    step();
    run_pass(1'b0, 4, -1);    // start re-pulsed at tap 5 and in DONE
    step();
    run_pass(1'b0, -1, 19);   // abort at tap 20
    run_pass(1'b0, -1, -1);   // fresh pass after abort starts at addr 0
    step();

    // Reset mid-pass, together with start
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("midpass_busy", v_busy, 1);
    rst = 1'b1; start = 1'b1;
    step();
    check_idle_zero("rst_mid");
    rst = 1'b0; start = 1'b0;
    step();
    check("rst_idle_valid", v_valid, 0);
    check("rst_idle_busy", v_busy, 0);

    // Instance B: stride 2
    sel = 1'b1;
    cfg_w = 5; cfg_k = 3; cfg_s = 2; cfg_ow = 2; cfg_oh = 2;
    step();
    run_pass(1'b1, -1, -1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
